// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the issue controller: op classes, FSM states and the decoded-op slot.
package issue_scoreboard_pkg;

  localparam logic [4:0] OP_ARITHMETIC = 5'd0;
  localparam logic [4:0] OP_MEMORY     = 5'd1;
  localparam logic [4:0] OP_BRANCH     = 5'd2;
  localparam logic [4:0] OP_JUMP       = 5'd3;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_BR_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0]  op_type;
    logic [6:0]  op_spec;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        use_rs1;
    logic        use_rs2;
    logic        wr_rd;
  } op_t;

  function automatic logic is_ctrl(input logic [4:0] t);
    return (t == OP_BRANCH) || (t == OP_JUMP);
  endfunction

  function automatic logic [31:0] onehot32(input logic [4:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/issue_scoreboard_reg_scoreboard.sv
// Register busy bits plus in-flight writer counter; writeback is exposed a cycle early
// through busy_eff_o/count_eff_o so the issue check can bypass it.
module reg_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en_i,
  input  logic [4:0]       set_idx_i,
  input  logic             clr_en_i,
  input  logic [4:0]       clr_idx_i,
  output logic [31:0]      busy_o,
  output logic [31:0]      busy_eff_o,
  output logic [CNT_W-1:0] count_eff_o
);

  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             set_v, clr_v;

  // x0 is hardwired, so neither a set nor a clear of index 0 has any effect
  assign set_v = set_en_i && (set_idx_i != 5'd0);
  assign clr_v = clr_en_i && (clr_idx_i != 5'd0);

  always_comb begin
    busy_eff_o  = busy_q & ~(clr_v ? onehot32(clr_idx_i) : 32'd0);
    count_eff_o = (clr_v && (count_q != '0)) ? count_q - CNT_W'(1) : count_q;
    // Set is applied after clear so a same-cycle reissue of the same rd stays busy
    busy_d      = busy_eff_o | (set_v ? onehot32(set_idx_i) : 32'd0);
    count_d     = count_eff_o + (set_v ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Single-slot issue stage: holds one decoded op, blocks on RAW/WAW hazards, the in-flight
// writer cap and unresolved control flow, and hands off to execute with valid/ready.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op_type,
  input  logic [6:0]  in_op_spec,
  input  logic [31:0] in_imm,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        in_use_rs1,
  input  logic        in_use_rs2,
  input  logic        in_wr_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_op_type,
  output logic [6:0]  out_op_spec,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_wr_rd,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        resolve_valid,
  input  logic        flush,
  output logic [31:0] busy
);

  state_e           state_q, state_d;
  op_t              slot_q, in_op;
  logic             hazard, issue, accept;
  logic [31:0]      busy_eff;
  logic [CNT_W-1:0] count_eff;

  assign in_op = '{op_type: in_op_type, op_spec: in_op_spec, imm: in_imm,
                   rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                   use_rs1: in_use_rs1, use_rs2: in_use_rs2, wr_rd: in_wr_rd};

  reg_scoreboard #(
    .MAX_INFLIGHT(MAX_INFLIGHT),
    .CNT_W       (CNT_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (issue && slot_q.wr_rd),
    .set_idx_i  (slot_q.rd),
    .clr_en_i   (wb_valid),
    .clr_idx_i  (wb_rd),
    .busy_o     (busy),
    .busy_eff_o (busy_eff),
    .count_eff_o(count_eff)
  );

  always_comb begin
    hazard = (slot_q.use_rs1 && (slot_q.rs1 != 5'd0) && busy_eff[slot_q.rs1]) ||
             (slot_q.use_rs2 && (slot_q.rs2 != 5'd0) && busy_eff[slot_q.rs2]) ||
             (slot_q.wr_rd   && (slot_q.rd  != 5'd0) && busy_eff[slot_q.rd])  ||
             (slot_q.wr_rd   && (count_eff == CNT_W'(MAX_INFLIGHT)));
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // FSM: handshake outputs; a control op never refills the slot on its issue cycle
  always_comb begin
    out_valid = (state_q == ST_HOLD) && !hazard && !flush;
    issue     = out_valid && out_ready;
    in_ready  = !flush && ((state_q == ST_EMPTY) || (issue && !is_ctrl(slot_q.op_type)));
    accept    = in_valid && in_ready;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY:   if (accept) state_d = ST_HOLD;
        ST_HOLD:    if (issue) begin
                      if (is_ctrl(slot_q.op_type)) state_d = ST_BR_WAIT;
                      else                         state_d = accept ? ST_HOLD : ST_EMPTY;
                    end
        ST_BR_WAIT: if (resolve_valid) state_d = ST_EMPTY;
        default:    state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         slot_q <= '0;
    else if (accept) slot_q <= in_op;
  end

  assign out_op_type = slot_q.op_type;
  assign out_op_spec = slot_q.op_spec;
  assign out_imm     = slot_q.imm;
  assign out_rs1     = slot_q.rs1;
  assign out_rs2     = slot_q.rs2;
  assign out_rd      = slot_q.rd;
  assign out_wr_rd   = slot_q.wr_rd;

endmodule
